// File: rtl/mux_nch_rr.sv
// N-channel registered selector with valid/ready on both sides.
// Manual mode picks `sel`; auto mode scans channels round-robin from the last auto grant.
module mux_nch_rr #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] data_p1;
    logic [IDX_W-1:0]  ch_p1;
    logic              vld_p1;
    logic              sel_err_p1;
    logic [IDX_W-1:0]  last_p1;

    logic              load;
    logic              sel_in_range;
    logic [IDX_W-1:0]  man_idx;
    logic              man_hit;
    logic [IDX_W:0]    rr_res;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              xfer;
    logic [DATA_W-1:0] grant_data;

    // First valid channel after `last`, wrapping, with `last` itself checked last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CH-1:0] v,
                                               input logic [IDX_W-1:0]  last);
        logic [IDX_W-1:0] k;
        logic             found;
        logic [IDX_W-1:0] idx;
        k     = last;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (k == IDX_W'(NUM_CH - 1)) ? '0 : k + IDX_W'(1);
            if (!found && v[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    // sel is compared at full width so large out-of-range values are never aliased.
    assign sel_in_range = (32'(sel) < 32'(NUM_CH));
    assign man_idx      = sel[IDX_W-1:0];
    assign man_hit      = sel_in_range && in_valid[man_idx];
    assign rr_res       = rr_pick(in_valid, last_p1);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_valid = rr_res[IDX_W];
            grant_idx   = rr_res[IDX_W-1:0];
        end else begin
            grant_valid = man_hit;
            grant_idx   = man_idx;
        end
    end

    assign load       = !vld_p1 || out_ready;
    assign xfer       = load && grant_valid && !rst;
    assign grant_data = in_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant_idx] = 1'b1;
    end

    // Stage p1: output register, round-robin pointer and select-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            ch_p1      <= '0;
            sel_err_p1 <= 1'b0;
            last_p1    <= IDX_W'(NUM_CH - 1);
        end else begin
            sel_err_p1 <= !mode && !sel_in_range;
            if (xfer) begin
                vld_p1  <= 1'b1;
                data_p1 <= grant_data;
                ch_p1   <= grant_idx;
                if (mode) last_p1 <= grant_idx;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_ch    = SEL_W'(ch_p1);
    assign out_valid = vld_p1;
    assign sel_err   = sel_err_p1;

endmodule
